// File: rtl/orao_autotype_if.sv
// Start request and synthetic keyboard/reset outputs of the Orao autotyper.
interface orao_autotype_if;
  logic       start;
  logic       n_reset_out;
  logic       key_b;
  logic       key_c;
  logic       key_enter;
  logic       busy;
  logic [3:0] step;

  modport master (
    output start,
    input  n_reset_out,
    input  key_b,
    input  key_c,
    input  key_enter,
    input  busy,
    input  step
  );

  modport slave (
    input  start,
    output n_reset_out,
    output key_b,
    output key_c,
    output key_enter,
    output busy,
    output step
  );
endinterface

// File: rtl/orao_autotype.sv
// Orao autotyper: resets the core, then types B, C, ENTER, ENTER in fixed-length
// slots; optionally repeats after a holdoff of idle slots.
module orao_autotype #(
  parameter int unsigned SLOT_BITS  = 22,
  parameter int unsigned IDLE_SLOTS = 16,
  parameter int unsigned LOOP       = 1
) (
  input  logic             clk,
  input  logic             reset,
  orao_autotype_if.slave   bus
);

  localparam int unsigned SLOT_W    = SLOT_BITS;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned LAST_SLOT = 8;
  localparam int unsigned STEP_IDLE = 9;
  localparam int unsigned HOLD_W    = (IDLE_SLOTS > 1) ? $clog2(IDLE_SLOTS) : 1;
  localparam int unsigned HOLD_LAST = (IDLE_SLOTS == 0) ? 0 : IDLE_SLOTS - 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HOLDOFF = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_slot;
  logic [SLOT_W-1:0]   r_cnt;
  logic [HOLD_W-1:0]   r_hold;

  logic                w_wrap;
  logic                w_n_reset;
  logic                w_key_b;
  logic                w_key_c;
  logic                w_key_enter;
  logic                w_busy;
  logic [IDX_W-1:0]    w_step;

  // Slot counter is about to roll over from all-ones to zero.
  assign w_wrap = &r_cnt;

  // Sequencer: walks the script slots, then holdoff or waits for start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_slot  <= '0;
      r_cnt   <= '0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          // start is deliberately ignored while the script runs
          r_cnt <= r_cnt + SLOT_W'(1);
          if (w_wrap) begin
            if (r_slot == IDX_W'(LAST_SLOT)) begin
              r_state <= (LOOP != 0) ? ST_HOLDOFF : ST_DONE;
              r_slot  <= '0;
              r_hold  <= '0;
            end else begin
              r_slot <= r_slot + IDX_W'(1);
            end
          end
        end

        ST_HOLDOFF: begin
          if (bus.start || (IDLE_SLOTS == 0)) begin
            r_state <= ST_RUN;
            r_slot  <= '0;
            r_cnt   <= '0;
            r_hold  <= '0;
          end else begin
            r_cnt <= r_cnt + SLOT_W'(1);
            if (w_wrap) begin
              if (r_hold == HOLD_W'(HOLD_LAST)) begin
                r_state <= ST_RUN;
                r_slot  <= '0;
                r_hold  <= '0;
              end else begin
                r_hold <= r_hold + HOLD_W'(1);
              end
            end
          end
        end

        ST_DONE: begin
          if (bus.start) begin
            r_state <= ST_RUN;
            r_slot  <= '0;
            r_cnt   <= '0;
            r_hold  <= '0;
          end
        end

        default: begin
          r_state <= ST_RUN;
          r_slot  <= '0;
          r_cnt   <= '0;
          r_hold  <= '0;
        end
      endcase
    end
  end

  // Output decode from state, slot index and reset; no extra pipeline stage so
  // pulses line up exactly with slot boundaries and reset acts immediately.
  always_comb begin
    w_n_reset   = 1'b1;
    w_key_b     = 1'b0;
    w_key_c     = 1'b0;
    w_key_enter = 1'b0;
    w_busy      = 1'b0;
    w_step      = IDX_W'(STEP_IDLE);
    if (reset) begin
      w_n_reset = 1'b0;
      w_busy    = 1'b1;
      w_step    = '0;
    end else if (r_state == ST_RUN) begin
      w_busy = 1'b1;
      w_step = r_slot;
      case (r_slot)
        IDX_W'(0): w_n_reset   = 1'b0;
        IDX_W'(2): w_key_b     = 1'b1;
        IDX_W'(4): w_key_c     = 1'b1;
        IDX_W'(6): w_key_enter = 1'b1;
        IDX_W'(8): w_key_enter = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.n_reset_out = w_n_reset;
  assign bus.key_b       = w_key_b;
  assign bus.key_c       = w_key_c;
  assign bus.key_enter   = w_key_enter;
  assign bus.busy        = w_busy;
  assign bus.step        = w_step;

endmodule

// File: doc/orao_autotype.md
ORAO_AUTOTYPE -- requirements
Module: orao_autotype

Interface
REQ-001 SLOT_BITS, 22, slot length = 2^SLOT_BITS clocks (about 0.17 s at 25 MHz).
REQ-002 IDLE_SLOTS, 16, slots spent in HOLDOFF before the script restarts; 0 = restart on the next clock.
REQ-003 LOOP, 1, 1 = script repeats automatically; 0 = script runs once, then waits for start.
REQ-004 clk  input  1  pixel clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to rerun the script; sampled on clk.
REQ-007 n_reset_out  output  1  active-low reset to the computer core.
REQ-008 key_b  output  1  active-high synthetic "B" key.
REQ-009 key_c  output  1  active-high synthetic "C" key.
REQ-010 key_enter  output  1  active-high synthetic ENTER key.
REQ-011 busy  output  1  high while the script runs.
REQ-012 step  output  4  current script slot index 0..8; reads 9 when not running.

Function
REQ-013 The block SHALL implement states RUN, HOLDOFF and DONE, plus a 4-bit slot index and a SLOT_BITS-wide slot counter.
REQ-014 In RUN, the slot counter SHALL increment every clock; on wrap from all-ones to 0, the slot index SHALL increment.
REQ-015 The script SHALL be:
  - slot 0: n_reset_out=0
  - slot 1: idle
  - slot 2: key_b=1
  - slot 3: idle
  - slot 4: key_c=1
  - slot 5: idle
  - slot 6: key_enter=1
  - slot 7: idle
  - slot 8: key_enter=1
REQ-016 In idle slots and in any non-RUN state, outputs SHALL be n_reset_out=1, key_b=0, key_c=0, key_enter=0.
REQ-017 All outputs SHALL be decoded from the state, slot index and reset only; there SHALL be no additional pipeline delay, and outputs change on the clock edge that enters the slot.
REQ-018 At the wrap at the end of slot 8, the next state SHALL be HOLDOFF if LOOP=1, otherwise DONE; step SHALL read 9 and busy SHALL read 0.
REQ-019 HOLDOFF SHALL count IDLE_SLOTS full slots, then enter RUN slot 0 with the slot counter at 0.
REQ-020 If IDLE_SLOTS=0, HOLDOFF SHALL last exactly one clock.
REQ-021 DONE SHALL hold until start=1, then enter RUN slot 0 with the slot counter at 0 on the next clock.
REQ-022 start=1 in HOLDOFF SHALL abort the holdoff and enter RUN slot 0 on the next clock, with counters cleared.
REQ-023 start=1 in RUN SHALL be ignored; the sequence SHALL continue undisturbed.
REQ-024 start=1 on the same clock as the end-of-slot-8 wrap SHALL be ignored; the transition to HOLDOFF/DONE SHALL occur as normal.
REQ-025 Each output pulse SHALL last exactly 2^SLOT_BITS clocks.
REQ-026 Keys SHALL never be asserted simultaneously with each other or with n_reset_out=0.
REQ-027 The slot index SHALL never exceed 8 in RUN; step SHALL never show values 10..15.

Reset
REQ-028 While reset=1:
  - n_reset_out=0
  - key_b=0, key_c=0, key_enter=0
  - busy=1
  - step=0
  - state RUN, slot 0, all counters 0
REQ-029 On the first clock after reset falls, the script SHALL run from slot 0 cycle 0, so the core stays in reset for 2^SLOT_BITS clocks after reset deassertion.
REQ-030 Reset asserted mid-script or mid-holdoff SHALL take effect on the next edge, with the full restart behaviour of REQ-028.

Verification (SLOT_BITS=3, IDLE_SLOTS=2 unless stated)
REQ-031 Release reset at cycle 0 ->
  - n_reset_out=0 for cycles 0-7
  - key_b=1 for cycles 16-23
  - key_c=1 for cycles 32-39
  - key_enter=1 for cycles 48-55 and 64-71
  - busy falls at cycle 72
REQ-032 LOOP=1, no start -> HOLDOFF for cycles 72-87; n_reset_out=0 again for cycles 88-95; step returns to 0 at cycle 88.
REQ-033 LOOP=0 -> DONE from cycle 72 with outputs idle indefinitely; start pulse at cycle 100 -> busy=1 and n_reset_out=0 for cycles 101-108.
REQ-034 Pulse start at cycles 20 and 71 -> no effect: waveform identical to REQ-031.
REQ-035 Assert reset at cycle 35 for 2 cycles ->
  - key_c drops at cycle 35
  - n_reset_out=0 for cycles 35-36
  - new slot 0 spans cycles 37-44
REQ-036 IDLE_SLOTS=0, LOOP=1 -> HOLDOFF only at cycle 72; slot 0 restarts at cycle 73.
